// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480 @ 60 Hz VGA raster timing.
// Pixel divider, h/v counters, sync decode, strobes.
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_START = 144,
  parameter int H_END   = 783,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2,
  parameter int V_START = 35,
  parameter int V_END   = 514
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       pixel_en,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYN_L  = 10'(H_SYNC);
  localparam logic [9:0] V_SYN_L  = 10'(V_SYNC);
  localparam logic [9:0] H_STA_L  = 10'(H_START);
  localparam logic [9:0] H_END_L  = 10'(H_END);
  localparam logic [9:0] V_STA_L  = 10'(V_START);
  localparam logic [9:0] V_END_L  = 10'(V_END);

  logic [3:0] div_cnt;
  logic       h_wrap;
  logic       v_wrap;

  // the last clk of a pixel is where counters advance
  assign pixel_en = (div_cnt == DIV_LAST);
  assign h_wrap   = pixel_en && (hCount == H_LAST);
  assign v_wrap   = h_wrap && (vCount == V_LAST);

  // pixel clock divider, 0..CLK_DIV-1
  always_ff @(posedge clk) begin
    if (rst)
      div_cnt <= '0;
    else if (pixel_en)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 4'd1;
  end

  // horizontal position, one step per pixel
  always_ff @(posedge clk) begin
    if (rst)
      hCount <= '0;
    else if (h_wrap)
      hCount <= '0;
    else if (pixel_en)
      hCount <= hCount + 10'd1;
  end

  // vertical position, one step per line wrap
  always_ff @(posedge clk) begin
    if (rst)
      vCount <= '0;
    else if (v_wrap)
      vCount <= '0;
    else if (h_wrap)
      vCount <= vCount + 10'd1;
  end

  // strobes land in the first cycle of the new position
  always_ff @(posedge clk) begin
    if (rst) begin
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      line_tick  <= h_wrap;
      frame_tick <= v_wrap;
    end
  end

  // sync and display window decoded from presented counters
  always_comb begin
    hSync  = (hCount >= H_SYN_L);
    vSync  = (vCount >= V_SYN_L);
    bright = (hCount >= H_STA_L) && (hCount <= H_END_L) &&
             (vCount >= V_STA_L) && (vCount <= V_END_L);
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen.
// Default, reduced-raster and CLK_DIV=1 instances.
module tb_vga_sync_gen;

  localparam int S_DIV = 4;
  localparam int S_HT  = 40;
  localparam int S_HS  = 5;
  localparam int S_HST = 8;
  localparam int S_HEN = 35;
  localparam int S_VT  = 20;
  localparam int S_VS  = 2;
  localparam int S_VST = 3;
  localparam int S_VEN = 17;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic hs, vs, br, pe, lt, ft;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  logic rst_u = 1'b1;

  logic [9:0] d_h, d_v, s_h, s_v, u_h, u_v;
  logic d_hs, d_vs, d_br, d_pe, d_lt, d_ft;
  logic s_hs, s_vs, s_br, s_pe, s_lt, s_ft;
  logic u_hs, u_vs, u_br, u_pe, u_lt, u_ft;

  vga_sync_gen u_def (
    .clk(clk), .rst(rst_d),
    .hSync(d_hs), .vSync(d_vs), .bright(d_br),
    .hCount(d_h), .vCount(d_v), .pixel_en(d_pe),
    .line_tick(d_lt), .frame_tick(d_ft)
  );

  vga_sync_gen #(
    .CLK_DIV(S_DIV), .H_TOTAL(S_HT), .H_SYNC(S_HS),
    .H_START(S_HST), .H_END(S_HEN), .V_TOTAL(S_VT),
    .V_SYNC(S_VS), .V_START(S_VST), .V_END(S_VEN)
  ) u_small (
    .clk(clk), .rst(rst_s),
    .hSync(s_hs), .vSync(s_vs), .bright(s_br),
    .hCount(s_h), .vCount(s_v), .pixel_en(s_pe),
    .line_tick(s_lt), .frame_tick(s_ft)
  );

  vga_sync_gen #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst_u),
    .hSync(u_hs), .vSync(u_vs), .bright(u_br),
    .hCount(u_h), .vCount(u_v), .pixel_en(u_pe),
    .line_tick(u_lt), .frame_tick(u_ft)
  );

  int sel = 0;
  obs_t o;

  always_comb begin
    case (sel)
      0: o = '{d_h, d_v, d_hs, d_vs, d_br, d_pe, d_lt, d_ft};
      1: o = '{s_h, s_v, s_hs, s_vs, s_br, s_pe, s_lt, s_ft};
      default:
        o = '{u_h, u_v, u_hs, u_vs, u_br, u_pe, u_lt, u_ft};
    endcase
  end

  int checks = 0;
  int errors = 0;
  int n = 0;
  obs_t exp_q[$];

  int D, HT, HS, HST, HEN, VT, VS, VST, VEN;

  int hs_low, vs_low, bright_px, lt_cnt, ft_cnt;
  int prev_lt, prev_ft;
  int seen_b, fb_h, fb_v, lb_h, lb_v;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0d expected=%0d",
             tag, n, obs, exp);
    end
  endtask

  task automatic set_params(input int s);
    if (s == 1) begin
      D = S_DIV; HT = S_HT; HS = S_HS; HST = S_HST; HEN = S_HEN;
      VT = S_VT; VS = S_VS; VST = S_VST; VEN = S_VEN;
    end else begin
      D = (s == 2) ? 1 : 4;
      HT = 800; HS = 96; HST = 144; HEN = 783;
      VT = 525; VS = 2; VST = 35; VEN = 514;
    end
  endtask

  // independent arithmetic model: n cycles after reset release
  function automatic obs_t model(input int k);
    obs_t e;
    int dv, p, h, v;
    dv = k % D;
    p = k / D;
    h = p % HT;
    v = (p / HT) % VT;
    e.h = 10'(h);
    e.v = 10'(v);
    e.pe = (dv == D - 1);
    e.hs = (h >= HS);
    e.vs = (v >= VS);
    e.br = (h >= HST) && (h <= HEN) && (v >= VST) && (v <= VEN);
    e.lt = (k > 0) && (dv == 0) && (h == 0);
    e.ft = e.lt && (v == 0);
    return e;
  endfunction

  task automatic clear_meas();
    hs_low = 0; vs_low = 0; bright_px = 0;
    lt_cnt = 0; ft_cnt = 0;
    prev_lt = -1; prev_ft = -1;
    seen_b = 0; fb_h = -1; fb_v = -1; lb_h = -1; lb_v = -1;
  endtask

  task automatic account();
    int L, F;
    L = HT * D;
    F = L * VT;
    if (n < L && !o.hs) hs_low++;
    if (n >= F && n < 2 * F && !o.vs) vs_low++;
    if (n < F && o.br && o.pe) begin
      bright_px++;
      if (seen_b == 0) begin
        fb_h = int'(o.h); fb_v = int'(o.v); seen_b = 1;
      end
      lb_h = int'(o.h); lb_v = int'(o.v);
    end
    if (o.lt === 1'b1) begin
      if (prev_lt >= 0) chk("line_period", n - prev_lt, L);
      prev_lt = n;
      lt_cnt++;
    end
    if (o.ft === 1'b1) begin
      chk("lt_with_ft", o.lt, 1);
      if (prev_ft >= 0) chk("frame_period", n - prev_ft, F);
      else chk("first_frame_tick", n, F);
      prev_ft = n;
      ft_cnt++;
    end
  endtask

  task automatic check_pop();
    obs_t e;
    e = exp_q.pop_front();
    chk("hCount", o.h, e.h);
    chk("vCount", o.v, e.v);
    chk("hSync", o.hs, e.hs);
    chk("vSync", o.vs, e.vs);
    chk("bright", o.br, e.br);
    chk("pixel_en", o.pe, e.pe);
    chk("line_tick", o.lt, e.lt);
    chk("frame_tick", o.ft, e.ft);
    account();
  endtask

  task automatic set_rst(input logic val);
    case (sel)
      0: rst_d = val;
      1: rst_s = val;
      default: rst_u = val;
    endcase
  endtask

  task automatic do_reset();
    set_rst(1'b1);
    repeat (3) @(posedge clk);
    #1;
    clear_meas();
    n = 0;
    exp_q.push_back(model(0));
    set_rst(1'b0);
    check_pop();
  endtask

  task automatic step();
    exp_q.push_back(model(n + 1));
    @(posedge clk);
    #1;
    n++;
    check_pop();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  int target;

  initial begin
    // default timing: reset, divider, two lines
    sel = 0;
    set_params(0);
    do_reset();
    run(6500);
    chk("A_hsync_low", hs_low, 384);
    chk("A_line_ticks", lt_cnt, 2);
    chk("A_frame_ticks", ft_cnt, 0);

    // reduced raster: two full frames
    sel = 1;
    set_params(1);
    do_reset();
    run(2 * S_HT * S_VT * S_DIV + 10);
    chk("B_hsync_low", hs_low, S_HS * S_DIV);
    chk("B_vsync_low", vs_low, S_VS * S_HT * S_DIV);
    chk("B_bright_px", bright_px,
        (S_HEN - S_HST + 1) * (S_VEN - S_VST + 1));
    chk("B_first_b_h", fb_h, S_HST);
    chk("B_first_b_v", fb_v, S_VST);
    chk("B_last_b_h", lb_h, S_HEN);
    chk("B_last_b_v", lb_v, S_VEN);
    chk("B_frame_ticks", ft_cnt, 2);
    chk("B_line_ticks", lt_cnt, 2 * S_VT);

    // mid-frame reset on a pixel_en cycle at (25,12)
    target = 2 * S_HT * S_VT * S_DIV +
             (12 * S_HT + 25) * S_DIV + S_DIV - 1;
    while (n < target) step();
    chk("pre_rst_h", o.h, 25);
    chk("pre_rst_v", o.v, 12);
    chk("pre_rst_pe", o.pe, 1);
    set_rst(1'b1);
    exp_q.push_back(model(0));
    @(posedge clk);
    #1;
    set_rst(1'b0);
    clear_meas();
    n = 0;
    check_pop();
    run(S_HT * S_VT * S_DIV + 10);
    chk("C_hsync_low", hs_low, S_HS * S_DIV);
    chk("C_bright_px", bright_px,
        (S_HEN - S_HST + 1) * (S_VEN - S_VST + 1));
    chk("C_frame_ticks", ft_cnt, 1);
    chk("C_line_ticks", lt_cnt, S_VT);

    // CLK_DIV=1: pixel every clk, 800-clk lines
    sel = 2;
    set_params(2);
    do_reset();
    run(1700);
    chk("D_hsync_low", hs_low, 96);
    chk("D_line_ticks", lt_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock: horizontal and vertical sync pulses, the `bright` display-enable, and the `hCount`/`vCount` raster position. Every pixel-drawing controller consumes these signals: it reads `hCount`, `vCount` and `bright` and returns a 12-bit `rgb`. The block also emits per-pixel, per-line and per-frame strobes, so game logic can advance object positions once per frame without a separate slow clock.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per pixel; legal range 1..16.
- `H_TOTAL`, 800: pixels per line, counted from the start of hSync.
- `H_SYNC`, 96: hSync low width, in pixels.
- `H_START`, 144: first visible `hCount`.
- `H_END`, 783: last visible `hCount`.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC`, 2: vSync low width, in lines.
- `V_START`, 35: first visible `vCount`.
- `V_END`, 514: last visible `vCount`.

Ports:
- `clk` in 1: 100 MHz system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `hSync` out 1: horizontal sync, active low.
- `vSync` out 1: vertical sync, active low.
- `bright` out 1: high only inside the visible window.
- `hCount` out 10: horizontal position, 0..H_TOTAL-1.
- `vCount` out 10: vertical position, 0..V_TOTAL-1.
- `pixel_en` out 1: high in the last `clk` cycle of each pixel period.
- `line_tick` out 1: one-`clk` pulse on the first cycle of each new line.
- `frame_tick` out 1: one-`clk` pulse on the first cycle of each new frame.

## Operation
- `div_cnt` is a 4-bit counter that runs 0..CLK_DIV-1 and wraps.
  - `pixel_en = (div_cnt == CLK_DIV-1)`.
  - With CLK_DIV=1, `pixel_en` is constantly 1.
- On a rising edge with `pixel_en`=1:
  - `hCount` increments.
  - At H_TOTAL-1, `hCount` wraps to 0 and `vCount` increments.
  - When `vCount` is at V_TOTAL-1 during that wrap, `vCount` also wraps to 0.
- `hCount` and `vCount` are unsigned 10-bit registers; all parameters are below 1024. No value outside 0..TOTAL-1 is ever presented.
- Sync and display-enable are pure functions of the currently presented counters, valid in the same cycle. They can be produced by combinational decode or by registering the next-state decode.
  - `hSync = (hCount >= H_SYNC)`
  - `vSync = (vCount >= V_SYNC)`
  - `bright = (H_START <= hCount <= H_END) && (V_START <= vCount <= V_END)`
- Line and frame strobes are registered. Each is high for exactly one `clk`, in the first cycle in which the new count is presented:
  - `line_tick`: `hCount` has just wrapped to 0.
  - `frame_tick`: both counters have just wrapped to 0.
  - A frame wrap asserts `line_tick` and `frame_tick` in the same cycle.
- Reset:
  - Sets `div_cnt`=0, `hCount`=0, `vCount`=0, `line_tick`=0, `frame_tick`=0.
  - Resulting outputs: `hSync`=0, `vSync`=0, `bright`=0, `pixel_en`=0 (1 if CLK_DIV=1).
  - Reset entry is not a wrap: no tick fires on the first cycle after reset.
- Reset mid-frame takes priority over any pending increment or wrap on the same edge.
  - The strobes are cleared.
  - The next frame starts at (0,0) with a full hSync/vSync pulse.

## Timing
- Pixel period: CLK_DIV `clk` cycles. The `hCount` value is stable for all CLK_DIV cycles of its pixel.
- Line period: H_TOTAL×CLK_DIV = 3200 `clk`.
- Frame period: V_TOTAL lines = 1,680,000 `clk`, which is 59.52 Hz at 100 MHz.
- Pulse widths:
  - hSync low: H_SYNC×CLK_DIV = 384 `clk` per line.
  - vSync low: V_SYNC lines = 6400 `clk`.
- `bright` is high for 640 pixels on each of 480 lines: 307,200 pixel periods per frame.
- Latency:
  - Counter change to sync/`bright` change: 0 cycles.
  - Wrap edge to tick: ticks are high in the cycle immediately after the wrap edge.
- First `frame_tick` after reset release: exactly 1,680,000 `clk` later.

## Test plan
- **Reset values:** hold `rst` 3 cycles, release → `hCount`=0, `vCount`=0, `hSync`=0, `vSync`=0, `bright`=0, `line_tick`=0, `frame_tick`=0.
- **Pixel divider:** after reset release, `pixel_en` high on cycles 3, 7, 11, … → `hCount` reads 1 at cycle 4 and 2 at cycle 8.
- **Horizontal timing:** count over one line:
  - `hSync` low for 384 `clk`.
  - `line_tick` pulses every 3200 `clk`.
  - `hCount` goes 799→0 with `vCount` incrementing on the same edge.
- **Vertical and frame timing:** run one full frame:
  - `vSync` low for exactly 6400 `clk` starting at `frame_tick`.
  - `bright`-high pixel periods = 307,200, first at (144,35) and last at (783,514).
  - `frame_tick` count = 1, with `line_tick` coincident.
  - Second `frame_tick` exactly 1,680,000 `clk` after the first.
- **Mid-frame reset:** assert `rst` for 1 cycle at `hCount`=500, `vCount`=300 → next cycle counters read (0,0), `hSync`=0, `vSync`=0, no tick. The following frame repeats the timing above.
- **CLK_DIV=1 instance:** `pixel_en` constantly 1 and `hCount` advances every `clk` → line period 800 `clk`, frame period 420,000 `clk`.
